// File: rtl/truth_table_scanner_if.sv
// Bundle between the scanner and its controller/function block.
// Optional fail-capture signals exist only when TT_FAIL_CAPTURE_EN is defined.
interface truth_table_scanner_if;
    logic        start;
    logic [15:0] expected;
    logic        f_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic [15:0] truth_table;
    logic        pass;
    logic [1:0]  dbg_state;
`ifdef TT_FAIL_CAPTURE_EN
    logic [3:0]  first_fail;
    logic        fail_valid;
`endif

    // start is a level request accepted only while busy is low; done is a
    // one-cycle pulse, and truth_table/pass stay valid until the next accept.
    modport master (
        output start, expected, f_in,
        input  a, b, c, d, busy, done, truth_table, pass, dbg_state
`ifdef TT_FAIL_CAPTURE_EN
        , input first_fail, fail_valid
`endif
    );

    modport slave (
        input  start, expected, f_in,
        output a, b, c, d, busy, done, truth_table, pass, dbg_state
`ifdef TT_FAIL_CAPTURE_EN
        , output first_fail, fail_valid
`endif
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks {a,b,c,d} through all 16 minterms, samples f_in after SETTLE cycles each,
// and compares the captured table to a latched mask. Optional: TT_FAIL_CAPTURE_EN.
module truth_table_scanner #(
    parameter int unsigned SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_scanner_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_FIN    = 2'd3
    } state_e;

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

    state_e      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  idx_d;
    logic [2:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] table_q;
    logic [15:0] exp_q;
`ifdef TT_FAIL_CAPTURE_EN
    logic [3:0]  first_fail_q;
    logic        fail_valid_q;
`endif

    assign idx_d = idx_q + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 4'd0;
            cnt_q        <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            table_q      <= 16'd0;
            exp_q        <= 16'd0;
`ifdef TT_FAIL_CAPTURE_EN
            first_fail_q <= 4'd0;
            fail_valid_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q      <= S_SETTLE;
                        idx_q        <= 4'd0;
                        cnt_q        <= 3'd0;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        table_q      <= 16'd0;
                        exp_q        <= bus.expected;
`ifdef TT_FAIL_CAPTURE_EN
                        first_fail_q <= 4'd0;
                        fail_valid_q <= 1'b0;
`endif
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_SAMPLE: begin
                    table_q[idx_q] <= bus.f_in;
`ifdef TT_FAIL_CAPTURE_EN
                    // Indices are visited in ascending order, so the first hit is the lowest.
                    if (!fail_valid_q && (bus.f_in != exp_q[idx_q])) begin
                        first_fail_q <= idx_q;
                        fail_valid_q <= 1'b1;
                    end
`endif
                    if (idx_q == 4'd15) begin
                        state_q <= S_FIN;
                    end else begin
                        idx_q   <= idx_d;
                        cnt_q   <= 3'd0;
                        state_q <= S_SETTLE;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    pass_q  <= (table_q == exp_q);
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The index register is the function-block drive; it holds in IDLE and FIN.
    assign bus.a           = idx_q[3];
    assign bus.b           = idx_q[2];
    assign bus.c           = idx_q[1];
    assign bus.d           = idx_q[0];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.truth_table = table_q;
    assign bus.dbg_state   = state_q;
`ifdef TT_FAIL_CAPTURE_EN
    assign bus.first_fail  = first_fail_q;
    assign bus.fail_valid  = fail_valid_q;
`endif
endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed and randomized scans of two scanner instances (SETTLE=1 and SETTLE=3)
// checked against a minterm-level reference model.
module tb_truth_table_scanner;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    truth_table_scanner_if u1 ();
    truth_table_scanner_if u3 ();

    truth_table_scanner #(.SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(u1.slave));
    truth_table_scanner #(.SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(u3.slave));

    logic        f_mode1;
    logic [15:0] fmask1;
    logic [15:0] fmask3;

    // Downstream function blocks: either the reference expression or a lookup mask.
    always_comb u1.f_in = f_mode1 ? fmask1[{u1.a, u1.b, u1.c, u1.d}]
                                  : (u1.a & (u1.d | (~u1.b & u1.c)));
    always_comb u3.f_in = fmask3[{u3.a, u3.b, u3.c, u3.d}];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_table(input bit use_mask, input logic [15:0] m);
        logic [15:0] t;
        t = 16'd0;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            if (use_mask) t[i] = m[i];
            else          t[i] = v[3] & (v[0] | (~v[2] & v[1]));
        end
        return t;
    endfunction

    function automatic int model_latency(input int s);
        return 16 * (s + 1) + 1;
    endfunction

    function automatic int model_first_fail(input logic [15:0] t, input logic [15:0] e);
        for (int i = 0; i < 16; i++) if (t[i] != e[i]) return i;
        return 0;
    endfunction

    // Starts a scan on the SETTLE=1 instance and counts cycles to done.
    task automatic scan1(input logic [15:0] exp_v, input bit inject, output int lat);
        @(negedge clk);
        u1.expected = exp_v;
        u1.start    = 1'b1;
        @(negedge clk);
        u1.start = 1'b0;
        check("accept_busy", u1.busy, 1);
        check("accept_pass_clr", u1.pass, 0);
        lat = 0;
        while (u1.done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (inject && lat == 10) begin
                u1.start    = 1'b1;
                u1.expected = 16'h0000;
            end
            if (inject && lat == 11) u1.start = 1'b0;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input logic [15:0] tbl,
                                input logic [15:0] exp_v);
        check({tag, "_latency"}, lat, model_latency(1));
        check({tag, "_table"}, u1.truth_table, tbl);
        check({tag, "_pass"}, u1.pass, (tbl == exp_v));
        check({tag, "_busy_low"}, u1.busy, 0);
`ifdef TT_FAIL_CAPTURE_EN
        check({tag, "_fail_valid"}, u1.fail_valid, (tbl != exp_v));
        if (tbl != exp_v) check({tag, "_first_fail"}, u1.first_fail, model_first_fail(tbl, exp_v));
`endif
    endtask

    initial begin
        int lat;
        int ndone;
        int first_done;
        int second_done;
        logic b33;
        logic b34;
        logic [15:0] exp_r;
        logic [15:0] tbl;

        reset = 1'b1;
        u1.start = 1'b0; u1.expected = 16'h0;
        u3.start = 1'b0; u3.expected = 16'h0;
        f_mode1 = 1'b0; fmask1 = 16'h0; fmask3 = 16'hFFFF;
        repeat (3) @(negedge clk);
        check("rst_busy", u1.busy, 0);
        check("rst_done", u1.done, 0);
        check("rst_pass", u1.pass, 0);
        check("rst_table", u1.truth_table, 0);
        check("rst_abcd", {u1.a, u1.b, u1.c, u1.d}, 0);
        check("rst3_busy", u3.busy, 0);
        reset = 1'b0;

        // Matching case
        tbl = model_table(0, 16'h0);
        scan1(16'hAE00, 0, lat);
        check_result("match", lat, tbl, 16'hAE00);
        check("match_table_const", u1.truth_table, 16'hAE00);
        @(negedge clk);
        check("done_one_cycle", u1.done, 0);
        repeat (5) @(negedge clk);
        check("idle_table_hold", u1.truth_table, tbl);
        check("idle_pass_hold", u1.pass, 1);
        check("idle_abcd_hold", {u1.a, u1.b, u1.c, u1.d}, 15);

        // Mismatch case
        scan1(16'hAE01, 0, lat);
        check_result("mismatch", lat, tbl, 16'hAE01);

        // Start pulse and expected change while busy
        scan1(16'hAE00, 1, lat);
        check_result("busy_start", lat, tbl, 16'hAE00);
        u1.expected = 16'hAE00;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (u1.done) ndone++;
        end
        check("busy_start_no_restart", ndone, 0);
        check("busy_start_idle", u1.busy, 0);

        // Latency scaling and index stepping on the SETTLE=3 instance
        @(negedge clk);
        u3.expected = 16'hFFFF;
        u3.start    = 1'b1;
        @(negedge clk);
        u3.start = 1'b0;
        lat = 0;
        check("s3_abcd_0", {u3.a, u3.b, u3.c, u3.d}, 0);
        while (u3.done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat < 64) check("s3_abcd_step", {u3.a, u3.b, u3.c, u3.d}, lat / 4);
        end
        check("s3_latency", lat, model_latency(3));
        check("s3_pass", u3.pass, 1);
        check("s3_table", u3.truth_table, 16'hFFFF);

        // Reset mid-scan
        @(negedge clk);
        u1.expected = 16'hAE00;
        u1.start    = 1'b1;
        @(negedge clk);
        u1.start = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_table_nonzero", (u1.truth_table != 16'h0), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", u1.busy, 0);
        check("midrst_table", u1.truth_table, 0);
        check("midrst_abcd", {u1.a, u1.b, u1.c, u1.d}, 0);
        check("midrst_done", u1.done, 0);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (u1.done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        scan1(16'hAE00, 0, lat);
        check_result("after_rst", lat, tbl, 16'hAE00);

        // Start held high across two scans
        @(negedge clk);
        u1.expected = 16'hAE00;
        u1.start    = 1'b1;
        ndone = 0; first_done = -1; second_done = -1; b33 = 1'bx; b34 = 1'bx;
        for (int n = 0; n < 68; n++) begin
            @(negedge clk);
            if (u1.done) begin
                ndone++;
                if (first_done < 0) first_done = n;
                else second_done = n;
            end
            if (n == 33) b33 = u1.busy;
            if (n == 34) b34 = u1.busy;
        end
        u1.start = 1'b0;
        check("held_done_count", ndone, 2);
        check("held_first_done", first_done, 33);
        check("held_second_done", second_done, 67);
        check("held_busy_gap", b33, 0);
        check("held_busy_restart", b34, 1);
        check("held_pass", u1.pass, 1);

        // Randomized functions and expected masks
        f_mode1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            fmask1 = 16'($urandom);
            exp_r  = ($urandom_range(0, 1) == 1) ? fmask1 : 16'($urandom);
            tbl    = model_table(1, fmask1);
            scan1(exp_r, 0, lat);
            check_result("rand", lat, tbl, exp_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL provide parameter SETTLE, default 1: cycles the input vector is held before f_in is sampled; legal range 1..7.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port start  input  1  scan request; sampled only in IDLE.
REQ-005 SHALL provide port expected  input  16  expected minterm mask; bit i = expected f for index i = {a,b,c,d}.
REQ-006 SHALL provide port f_in  input  1  output f of the downstream 4-input function block.
REQ-007 SHALL provide ports a, b, c, d  output  1 each  registered drive to the function block inputs.
REQ-008 SHALL provide port busy  output  1  high from start acceptance until done.
REQ-009 SHALL provide port done  output  1  one-cycle pulse at scan completion.
REQ-010 SHALL provide port table  output  16  captured truth table; bit i = sampled f_in for index i.
REQ-011 SHALL provide port pass  output  1  table equals latched expected; valid from done until the next start.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, SAMPLE, FIN.
- IDLE: busy=0.
- start=1 moves to SETTLE.
- Entering SETTLE: idx=0, settle count=0, table=0, pass=0, expected latched into an internal register.
REQ-013 SHALL drive {a,b,c,d}=idx in SETTLE and SAMPLE, and hold the last driven value in IDLE and FIN.
REQ-014 SHALL remain in SETTLE for exactly SETTLE cycles per index, then go to SAMPLE.
REQ-015 SHALL in SAMPLE write f_in into table[idx]. If idx=15, go to FIN; otherwise increment idx, clear the settle count and go to SETTLE.
REQ-016 SHALL index with a 4-bit idx. Wrap from 15 to 0 never occurs within a scan, because the exit to FIN happens at idx=15.
REQ-017 SHALL in FIN assert done for one cycle, register pass = (table == latched expected) in that same cycle, then return to IDLE.
REQ-018 SHALL give a start-to-done latency of exactly 16*(SETTLE+1)+1 cycles, counted from the cycle start is sampled high in IDLE.
REQ-019 SHALL assert busy in SETTLE, SAMPLE and FIN. busy SHALL deassert in the cycle after FIN.
REQ-020 SHALL ignore start while busy=1, and SHALL ignore changes to expected after start acceptance.
REQ-021 SHALL, when start is held high continuously, begin a new scan in the cycle after returning to IDLE.
REQ-022 SHALL hold table and pass stable in IDLE until the next accepted start.

Reset
REQ-023 SHALL on reset=1 at a clock edge force:
- state=IDLE;
- idx=0, settle count=0;
- a=b=c=d=0;
- busy=0, done=0, pass=0;
- table=0, latched expected=0.
REQ-024 SHALL abandon any in-progress scan on reset with no done pulse. Reset SHALL take priority over start in the same cycle.

Configuration
REQ-025 SHALL support macro TT_FAIL_CAPTURE_EN.
REQ-026 SHALL, with TT_FAIL_CAPTURE_EN defined, add outputs:
- first_fail (4): lowest idx where the sampled f_in differed from the latched expected[idx], captured in SAMPLE;
- fail_valid (1): set on the first mismatch of a scan.
REQ-027 SHALL clear both added outputs on reset and at start acceptance.
REQ-028 SHALL, without TT_FAIL_CAPTURE_EN, omit these ports and logic entirely; all other behaviour is identical.

Verification
REQ-029 SHALL cover the matching case:
- Stimulus: SETTLE=1, f_in driven by f = a&(d|(~b&c)), expected=16'hAE00, start pulse.
- Response: done after 33 cycles, table=16'hAE00, pass=1; with the macro, fail_valid=0.
REQ-030 SHALL cover the mismatch case:
- Stimulus: same setup, expected=16'hAE01.
- Response: table=16'hAE00, pass=0; with the macro, first_fail=0 and fail_valid=1.
REQ-031 SHALL cover latency scaling:
- Stimulus: SETTLE=3, f_in tied to 1, expected=16'hFFFF.
- Response: done after 65 cycles, pass=1, {a,b,c,d} steps 0..15 holding each value for 4 cycles.
REQ-032 SHALL cover start while busy:
- Stimulus: start pulsed again at cycle 10 of a scan, and expected changed to 0.
- Response: no restart, done at cycle 33, comparison uses the original expected.
REQ-033 SHALL cover reset mid-scan:
- Stimulus: reset asserted at cycle 20.
- Response: next cycle busy=0, table=0, a..d=0, no done pulse; a following start completes normally.
REQ-034 SHALL cover start held high:
- Stimulus: start tied to 1 across two scans.
- Response: second scan's busy rises in the cycle after the first scan returns to IDLE; exactly two done pulses in 68 cycles (SETTLE=1).
